// File: rtl/output_drain_engine_if.sv
// Output word stream: bridge data tagged with its source port and an end-of-drain marker.
// The master holds m_data/m_port/m_last stable while m_valid is high and m_ready is low.
interface output_drain_engine_if #(
  parameter int DATA_W = 32,
  parameter int PORT_W = 5
);
  logic [DATA_W-1:0] m_data;
  logic [PORT_W-1:0] m_port;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, m_port, m_last, m_valid, input m_ready);
  modport slave  (input m_data, m_port, m_last, m_valid, output m_ready);
endinterface

// File: rtl/output_drain_engine.sv
// Round-robin drain of bridge FIFOs onto a tagged stream; a word reaches m_valid one cycle after done0.
// A full output buffer drops rd_en0, so m_ready backpressure stalls bridge reads without loss.
module output_drain_engine #(
  parameter int DATA_W     = 32,
  parameter int NUM_PORTS  = 20,
  parameter int PORT_W     = 5,
  parameter int CNT_W      = 16,
  parameter int OBUF_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_PORTS-1:0]    port_mask,
  input  logic [CNT_W-1:0]        words_per_port,
  output logic [PORT_W-1:0]       port0,
  output logic                    rd_en0,
  input  logic [DATA_W-1:0]       d_out0,
  input  logic                    done0,
  output_drain_engine_if.master   m_if,
  output logic                    busy,
  output logic                    drain_done,
  output logic                    err_timeout
);
  localparam int TOT_W  = CNT_W + $clog2(NUM_PORTS + 1);
  localparam int PTR_W  = $clog2(OBUF_DEPTH);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE, S_ERR} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [PORT_W-1:0] port;
    logic              last;
  } obuf_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  rem [NUM_PORTS];
  logic [PORT_W-1:0] cur, cur_nxt;
  logic [PORT_W:0]   cand;
  logic [TOT_W-1:0]  tot, tot_start;
  logic [IDLE_W-1:0] idle_cnt;

  obuf_t             obuf [OBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count, count_nxt;
  logic              obuf_full, push, pop, flush, start_ok, push_last;

  assign obuf_full = (count == (PTR_W+1)'(OBUF_DEPTH));
  assign rd_en0    = (state == S_RUN) && (rem[cur] != '0) && !obuf_full && !abort;
  assign port0     = (state == S_RUN) ? cur : '0;
  assign push      = rd_en0 & done0;
  assign push_last = (tot == TOT_W'(1));
  assign pop       = m_if.m_valid & m_if.m_ready;
  assign flush     = abort | (state == S_ERR);
  assign start_ok  = start & ~abort & (state == S_IDLE);
  assign count_nxt = flush ? '0 : count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  assign m_if.m_valid = (count != '0);
  assign m_if.m_data  = obuf[rd_ptr].dat;
  assign m_if.m_port  = obuf[rd_ptr].port;
  assign m_if.m_last  = m_if.m_valid & obuf[rd_ptr].last;
  assign busy         = (state != S_IDLE);
  assign drain_done   = (state == S_DONE);

  always_comb begin
    tot_start = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (port_mask[i]) tot_start = tot_start + TOT_W'(words_per_port);
  end

  // Walk offsets from farthest to nearest so the nearest pending port wins; cur itself is skipped.
  always_comb begin
    cur_nxt = cur;
    cand    = '0;
    for (int i = NUM_PORTS - 1; i >= 1; i--) begin
      cand = {1'b0, cur} + (PORT_W+1)'(i);
      if (cand >= (PORT_W+1)'(NUM_PORTS)) cand = cand - (PORT_W+1)'(NUM_PORTS);
      if (rem[cand[PORT_W-1:0]] != '0) cur_nxt = cand[PORT_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nxt = (tot_start == '0) ? S_FLUSH : S_RUN;
      S_RUN: begin
        if (push && push_last) state_nxt = S_FLUSH;
        else if (!push && idle_cnt == IDLE_W'(TIMEOUT - 1)) state_nxt = S_ERR;
      end
      S_FLUSH: if (count_nxt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cur         <= '0;
      tot         <= '0;
      idle_cnt    <= '0;
      err_timeout <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rem[i] <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == S_ERR) err_timeout <= 1'b1;
      if (start_ok) begin
        for (int i = 0; i < NUM_PORTS; i++) rem[i] <= port_mask[i] ? words_per_port : '0;
        cur         <= '0;
        tot         <= tot_start;
        idle_cnt    <= '0;
        err_timeout <= 1'b0;
      end else if (state == S_RUN && !abort) begin
        cur <= cur_nxt;
        if (push) begin
          rem[cur] <= rem[cur] - 1'b1;
          tot      <= tot - 1'b1;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) obuf[wr_ptr] <= '{dat: d_out0, port: cur, last: push_last};
  end
endmodule
